// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host link: FSM states, default
// timing at 50 MHz, common keyboard command bytes and the parity helper.
package ps2_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    INHIBIT   = 4'd1,
    REQUEST   = 4'd2,
    WAIT_DEV  = 4'd3,
    DATA      = 4'd4,
    ACK       = 4'd5,
    WAIT_IDLE = 4'd6,
    DONE      = 4'd7,
    ERROR     = 4'd8
  } state_t;

  localparam int DEF_INHIBIT_CYCLES = 6000;
  localparam int DEF_SETUP_CYCLES   = 100;
  localparam int DEF_START_TIMEOUT  = 750000;
  localparam int DEF_XFER_TIMEOUT   = 100000;
  localparam int DEF_IDLE_TIMEOUT   = 100000;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one PS/2 line with a falling-edge strobe.
// Resets to the idle-high level so the release of reset never looks like an edge.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic fall
);

  logic meta;
  logic prev;

  // Synchronizer chain plus one stage of history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
    end else begin
      meta  <= din;
      level <= meta;
      prev  <= level;
    end
  end

  assign fall = prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked
// shift-out of one byte with odd parity, ACK check and bus-idle wait, with timeouts.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
  parameter int XFER_TIMEOUT   = DEF_XFER_TIMEOUT,
  parameter int IDLE_TIMEOUT   = DEF_IDLE_TIMEOUT
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic [7:0] TX_DATA,
  input  logic       TX_START,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       TX_ERROR,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT
);

  localparam int MAX_A = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
  localparam int MAX_B = (MAX_A > IDLE_TIMEOUT) ? MAX_A : IDLE_TIMEOUT;
  localparam int MAX_C = (MAX_B > INHIBIT_CYCLES) ? MAX_B : INHIBIT_CYCLES;
  localparam int MAX_T = (MAX_C > SETUP_CYCLES) ? MAX_C : SETUP_CYCLES;
  localparam int TW    = $clog2(MAX_T + 1);

  localparam logic [TW-1:0] TIMER_MAX    = {TW{1'b1}};
  localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] SETUP_LAST   = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] START_LIMIT  = TW'(START_TIMEOUT);
  localparam logic [TW-1:0] XFER_LIMIT   = TW'(XFER_TIMEOUT);
  localparam logic [TW-1:0] IDLE_LIMIT   = TW'(IDLE_TIMEOUT);

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          par, par_nxt;
  logic [3:0]    bitcnt, bitcnt_nxt;
  logic          clk_low, clk_low_nxt;
  logic          dat_low, dat_low_nxt;
  logic          busy, busy_nxt;
  logic          done, done_nxt;
  logic          error, error_nxt;

  logic clk_level, clk_fall;
  logic dat_level, dat_fall_unused;

  ps2_sync_edge u_sync_clk (
    .clk   (CLOCK_50),
    .rst_n (Resetn),
    .din   (PS2_CLK),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_sync_edge u_sync_dat (
    .clk   (CLOCK_50),
    .rst_n (Resetn),
    .din   (PS2_DAT),
    .level (dat_level),
    .fall  (dat_fall_unused)
  );

  // State, datapath and line-driver registers; reset releases both lines at once.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      timer   <= '0;
      shift   <= 8'h00;
      par     <= 1'b0;
      bitcnt  <= 4'd0;
      clk_low <= 1'b0;
      dat_low <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      shift   <= shift_nxt;
      par     <= par_nxt;
      bitcnt  <= bitcnt_nxt;
      clk_low <= clk_low_nxt;
      dat_low <= dat_low_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      error   <= error_nxt;
    end
  end

  // Next-state and next-output logic; line drives are computed one cycle ahead.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = (timer == TIMER_MAX) ? timer : timer + TW'(1);
    shift_nxt   = shift;
    par_nxt     = par;
    bitcnt_nxt  = bitcnt;
    clk_low_nxt = clk_low;
    dat_low_nxt = dat_low;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    error_nxt   = 1'b0;

    case (state)
      IDLE: begin
        busy_nxt    = 1'b0;
        clk_low_nxt = 1'b0;
        dat_low_nxt = 1'b0;
        timer_nxt   = '0;
        if (TX_START) begin
          state_nxt   = INHIBIT;
          shift_nxt   = TX_DATA;
          par_nxt     = odd_parity(TX_DATA);
          bitcnt_nxt  = 4'd0;
          busy_nxt    = 1'b1;
          clk_low_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      INHIBIT: begin
        if (timer >= INHIBIT_LAST) begin
          state_nxt   = REQUEST;
          timer_nxt   = '0;
          dat_low_nxt = 1'b1;
        end else begin
          state_nxt = INHIBIT;
        end
      end
      REQUEST: begin
        if (timer >= SETUP_LAST) begin
          state_nxt   = WAIT_DEV;
          timer_nxt   = '0;
          clk_low_nxt = 1'b0;
        end else begin
          state_nxt = REQUEST;
        end
      end
      WAIT_DEV: begin
        if (clk_fall) begin
          state_nxt   = DATA;
          timer_nxt   = '0;
          dat_low_nxt = ~shift[0];
          shift_nxt   = {1'b0, shift[7:1]};
          bitcnt_nxt  = 4'd1;
        end else if (timer >= START_LIMIT) begin
          state_nxt   = ERROR;
          error_nxt   = 1'b1;
          clk_low_nxt = 1'b0;
          dat_low_nxt = 1'b0;
        end else begin
          state_nxt = WAIT_DEV;
        end
      end
      // The transfer timer keeps running from the first device edge through ACK.
      DATA: begin
        if (timer >= XFER_LIMIT) begin
          state_nxt   = ERROR;
          error_nxt   = 1'b1;
          clk_low_nxt = 1'b0;
          dat_low_nxt = 1'b0;
        end else if (clk_fall) begin
          bitcnt_nxt = bitcnt + 4'd1;
          if (bitcnt <= 4'd7) begin
            dat_low_nxt = ~shift[0];
            shift_nxt   = {1'b0, shift[7:1]};
          end else if (bitcnt == 4'd8) begin
            dat_low_nxt = ~par;
          end else begin
            dat_low_nxt = 1'b0;
            state_nxt   = ACK;
          end
        end else begin
          state_nxt = DATA;
        end
      end
      ACK: begin
        if (timer >= XFER_LIMIT) begin
          state_nxt   = ERROR;
          error_nxt   = 1'b1;
          clk_low_nxt = 1'b0;
          dat_low_nxt = 1'b0;
        end else if (clk_fall) begin
          if (!dat_level) begin
            state_nxt = WAIT_IDLE;
            timer_nxt = '0;
          end else begin
            state_nxt   = ERROR;
            error_nxt   = 1'b1;
            clk_low_nxt = 1'b0;
            dat_low_nxt = 1'b0;
          end
        end else begin
          state_nxt = ACK;
        end
      end
      WAIT_IDLE: begin
        if (clk_level && dat_level) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else if (timer >= IDLE_LIMIT) begin
          state_nxt   = ERROR;
          error_nxt   = 1'b1;
          clk_low_nxt = 1'b0;
          dat_low_nxt = 1'b0;
        end else begin
          state_nxt = WAIT_IDLE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
      ERROR: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt   = IDLE;
        busy_nxt    = 1'b0;
        clk_low_nxt = 1'b0;
        dat_low_nxt = 1'b0;
      end
    endcase
  end

  assign TX_BUSY  = busy;
  assign TX_DONE  = done;
  assign TX_ERROR = error;

  // Open-drain: only ever pull low or float.
  assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device that clocks
// at an 80-cycle period and samples host data on rising edges.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  logic       clk = 1'b0;
  logic       Resetn;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy, tx_done, tx_error;
  wire        ps2_clk, ps2_dat;
  logic       dev_clk_low, dev_dat_low;

  int passes = 0;
  int total = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int dev_edges = 0;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

  always #10 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (60),
    .SETUP_CYCLES   (10),
    .START_TIMEOUT  (2000),
    .XFER_TIMEOUT   (20000),
    .IDLE_TIMEOUT   (100000)
  ) dut (
    .CLOCK_50 (clk),
    .Resetn   (Resetn),
    .TX_DATA  (tx_data),
    .TX_START (tx_start),
    .TX_BUSY  (tx_busy),
    .TX_DONE  (tx_done),
    .TX_ERROR (tx_error),
    .PS2_CLK  (ps2_clk),
    .PS2_DAT  (ps2_dat)
  );

  always @(posedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("busy_after_start", tx_busy, 1);
  endtask

  // Device: wait for request-to-send, then clock up to n_edges falling edges.
  task automatic device_run(input int n_edges, input bit ack,
                            output logic [10:0] frame, output int low_cycles);
    bit seen;
    seen = 1'b0;
    frame = '0;
    low_cycles = 0;
    dev_edges = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (ps2_clk === 1'b0) low_cycles++;
      if (ps2_clk === 1'b1 && ps2_dat === 1'b0) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      $error("FAIL dev_rts: observed no request-to-send, expected CLK released with DAT low");
      return;
    end
    frame[0] = ps2_dat;
    repeat (20) @(negedge clk);
    for (int e = 1; e <= 10 && e <= n_edges; e++) begin
      dev_clk_low = 1'b1;
      dev_edges = e;
      repeat (40) @(negedge clk);
      dev_clk_low = 1'b0;
      frame[e] = ps2_dat;
      repeat (40) @(negedge clk);
    end
    if (n_edges >= 11) begin
      if (ack) dev_dat_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b1;
      dev_edges = 11;
      repeat (40) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (20) @(negedge clk);
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic expect_done(input string tag);
    for (int i = 0; i < 200 && !tx_done; i++) @(negedge clk);
    check({tag, "_done"}, tx_done, 1);
    check({tag, "_no_err"}, tx_error, 0);
    check({tag, "_busy_in_done"}, tx_busy, 1);
    @(negedge clk);
    check({tag, "_done_1cyc"}, tx_done, 0);
    check({tag, "_busy_fall"}, tx_busy, 0);
  endtask

  logic [7:0]  sweep_b [4] = '{8'h00, 8'h01, 8'hFF, 8'hF4};
  logic [10:0] sweep_f [4] = '{11'b1_1_00000000_0, 11'b1_0_00000001_0,
                               11'b1_1_11111111_0, 11'b1_0_11110100_0};

  initial begin
    logic [10:0] frame;
    int lowc, d, d0, e0;
    bit seen;
    Resetn = 1'b0;
    tx_start = 1'b0;
    tx_data = 8'h00;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_error", tx_error, 0);
    check("rst_clk_z", ps2_clk, 1);
    check("rst_dat_z", ps2_dat, 1);
    Resetn = 1'b1;
    repeat (5) @(negedge clk);

    // 0xED: odd parity bit 1
    send(CMD_SET_LEDS);
    device_run(11, 1'b1, frame, lowc);
    check("ed_inhibit_ge60", lowc >= 60, 1);
    check("ed_frame", frame, 11'b1_1_11101101_0);
    expect_done("ed");

    for (int k = 0; k < 4; k++) begin
      send(sweep_b[k]);
      device_run(11, 1'b1, frame, lowc);
      check("sweep_frame", frame, sweep_f[k]);
      expect_done("sweep");
    end

    // Silent device: start timeout
    d0 = done_cnt;
    send(CMD_ENABLE);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (ps2_clk === 1'b1 && ps2_dat === 1'b0) seen = 1'b1;
    end
    check("silent_release_seen", seen, 1);
    d = 0;
    while (!tx_error && d < 3000) begin
      @(negedge clk);
      d++;
    end
    check("silent_err_pulse", tx_error, 1);
    check("silent_timing", (d >= 1997 && d <= 2003), 1);
    check("silent_clk_z", ps2_clk, 1);
    check("silent_dat_z", ps2_dat, 1);
    check("silent_no_done", done_cnt, d0);
    @(negedge clk);
    check("silent_err_1cyc", tx_error, 0);
    check("silent_busy_low", tx_busy, 0);

    // Missing ACK, then a clean resend
    e0 = err_cnt;
    d0 = done_cnt;
    send(CMD_SET_LEDS);
    device_run(11, 1'b0, frame, lowc);
    repeat (5) @(negedge clk);
    check("nack_err_count", err_cnt, e0 + 1);
    check("nack_no_done", done_cnt, d0);
    check("nack_busy_low", tx_busy, 0);
    check("nack_clk_z", ps2_clk, 1);
    check("nack_dat_z", ps2_dat, 1);
    send(CMD_ENABLE);
    device_run(11, 1'b1, frame, lowc);
    check("retry_f4_frame", frame, 11'b1_0_11110100_0);
    expect_done("retry_f4");

    // TX_START and TX_DATA disturbed mid-transfer
    d0 = done_cnt;
    dev_edges = 0;
    send(CMD_SET_LEDS);
    fork
      device_run(11, 1'b1, frame, lowc);
      begin
        for (int i = 0; i < 3000 && dev_edges < 3; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        tx_data = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (50) @(negedge clk);
        tx_data = 8'h3C;
      end
    join
    check("busy_start_frame", frame, 11'b1_1_11101101_0);
    expect_done("busy_start");
    repeat (300) @(negedge clk);
    check("busy_start_one_done", done_cnt, d0 + 1);
    check("busy_start_idle", tx_busy, 0);

    // Async reset while data bit 4 is on the wire
    dev_edges = 0;
    send(CMD_SET_LEDS);
    fork
      device_run(5, 1'b1, frame, lowc);
      begin
        for (int i = 0; i < 3000 && dev_edges < 5; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        check("rst_mid_d4_low", ps2_dat, 0);
        Resetn = 1'b0;
        #1;
        check("rst_mid_dat_z", ps2_dat, 1);
        check("rst_mid_busy", tx_busy, 0);
        check("rst_mid_done", tx_done, 0);
        check("rst_mid_error", tx_error, 0);
      end
    join
    check("rst_mid_clk_z", ps2_clk, 1);
    repeat (5) @(negedge clk);
    Resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_after_busy", tx_busy, 0);
    send(CMD_RESET);
    device_run(11, 1'b1, frame, lowc);
    check("ff_frame", frame, 11'b1_1_11111111_0);
    expect_done("ff");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #1200000;
    $display("FAIL watchdog: observed no completion, expected finish within 60000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter; the send direction of the keyboard link whose receive side is the get_key shift register.
- Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the shared open-drain PS2_CLK/PS2_DAT pair.
- Runs the full inhibit/request-to-send/device-clocked/ACK sequence, with timeouts.

Parameters:
- INHIBIT_CYCLES, 6000: CLK held low before request (120 us at 50 MHz).
- SETUP_CYCLES, 100: CLK and DAT both low before CLK release (2 us).
- START_TIMEOUT, 750000: max cycles from CLK release to first device falling edge (15 ms).
- XFER_TIMEOUT, 100000: max cycles from first device falling edge to ACK (2 ms).
- IDLE_TIMEOUT, 100000: max cycles waiting for bus idle after ACK.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- Resetn  in  1  asynchronous active-low reset
- TX_DATA  in  8  byte to send; sampled only on an accepted TX_START
- TX_START  in  1  one-cycle request; ignored while TX_BUSY=1
- TX_BUSY  out  1  high from accepted start until DONE/ERROR cycle inclusive
- TX_DONE  out  1  one-cycle pulse: device ACKed and bus returned idle
- TX_ERROR  out  1  one-cycle pulse: timeout or missing ACK
- PS2_CLK  inout  1  open-drain; drive 0 or Z only
- PS2_DAT  inout  1  open-drain; drive 0 or Z only

Behaviour:
- Reset (async, Resetn=0): state IDLE; TX_BUSY=0, TX_DONE=0, TX_ERROR=0; both lines Z immediately. Reset mid-transfer behaves identically and leaves no residue.
- Inputs: PS2_CLK and PS2_DAT each pass through a 2-flop synchronizer. A device falling edge is sync_clk going from 1 to 0 (prev & !cur). Edge latency is about 3 cycles, which is negligible against a ~40 us PS/2 half-period.
- Accepted start: TX_START=1 in IDLE latches shift = TX_DATA and par = ~^TX_DATA (odd parity). TX_BUSY asserts the next cycle.
- INHIBIT: drive CLK=0, DAT=Z. Count INHIBIT_CYCLES, then go to REQUEST.
- REQUEST: drive CLK=0, DAT=0 (start bit). Count SETUP_CYCLES, then go to WAIT_DEV.
- WAIT_DEV: release CLK (Z), hold DAT=0, clear timer.
  - First falling edge: drive DAT per D0 (0 -> drive low, 1 -> Z); bitcnt=1; go to DATA; clear timer.
  - Timer reaching START_TIMEOUT: ERROR.
- DATA: on each falling edge increment bitcnt.
  - Edges 2-8 output D1..D7.
  - Edge 9 outputs parity.
  - Edge 10 releases DAT (stop bit = 1); go to ACK.
  - Data changes only on falling edges; the device samples on rising edges.
- ACK: on the 11th falling edge, sample sync_dat. 0 -> WAIT_IDLE; 1 -> ERROR.
  - XFER_TIMEOUT is counted continuously across DATA and ACK; reaching it gives ERROR.
- WAIT_IDLE: both lines Z. When sync_clk=1 and sync_dat=1 go to DONE. IDLE_TIMEOUT expiry gives ERROR.
- DONE: TX_DONE=1 for one cycle with TX_BUSY still 1; next cycle IDLE, TX_BUSY=0.
- ERROR: release both lines; TX_ERROR=1 for one cycle; then IDLE. No automatic retry.
- TX_DATA changes after acceptance have no effect. TX_START during TX_BUSY is dropped, not queued.
- Timer width: $clog2 of the largest timeout parameter plus 1 (20 bits at defaults); saturating compare, no wrap.
- The module never drives a line high.

Decomposition:
- ps2_pkg holds:
  - state enum {IDLE, INHIBIT, REQUEST, WAIT_DEV, DATA, ACK, WAIT_IDLE, DONE, ERROR};
  - default timing constants;
  - command byte constants: CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF, ACK_BYTE=8'hFA.
- Sub-module ps2_sync_edge: 2-flop synchronizer plus falling-edge detect, instantiated for PS2_CLK and also for PS2_DAT (level only). It is reusable by the receive path.

Test Plan:
- Test parameters: INHIBIT=60, SETUP=10, START_TIMEOUT=2000, XFER_TIMEOUT=20000. The device model clocks with an 80-cycle period once it sees CLK released with DAT low.
- Send 0xED -> CLK observed low for >=60 cycles. Device samples on rising edges: start 0; data 1,0,1,1,0,1,1,1; parity 1; stop 1. Model ACKs low; then one-cycle TX_DONE, no TX_ERROR, TX_BUSY falls the next cycle.
- Parity sweep: 0x00 -> parity 1; 0x01 -> parity 0; 0xFF -> parity 1; 0xF4 -> parity 0. Each ends with TX_DONE.
- Device silent after request -> TX_ERROR pulse 2000 cycles (+/-3) after CLK release. Both lines Z, TX_BUSY=0, no TX_DONE.
- Device clocks 11 edges but leaves DAT high at the ACK edge -> TX_ERROR pulse, lines Z, next send of 0xF4 succeeds.
- TX_START pulsed with 0x55 mid-DATA of 0xED, and TX_DATA changed mid-transfer -> bits on wire remain 0xED, exactly one TX_DONE.
- Resetn low at data bit 4 -> lines Z and all outputs 0 within the same cycle (async). After release, send 0xFF completes normally.
